// File: rtl/noc_link_mux.sv
// noc_link_mux: CH-channel wormhole round-robin NoC link mux with per-channel flit FIFOs.
// Define NOC_CONN_ERRCHK_EN to drop and flag flits that break header/tail framing.
module noc_link_mux #(
    parameter int CH        = 4,
    parameter int CH_W      = 2,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4,
    parameter int VC_THRESH = 2
) (
    input  logic                 noc_clk,
    input  logic                 rst,
    input  logic [CH-1:0]        in_valid,
    output logic [CH-1:0]        in_ready,
    input  logic [CH*DATA_W-1:0] in_flit,
    input  logic [CH-1:0]        in_is_header,
    input  logic [CH-1:0]        in_is_tail,
    output logic [CH-1:0]        in_vc_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_flit,
    output logic                 out_is_header,
    output logic                 out_is_tail,
    output logic [CH_W-1:0]      out_ch,
    output logic [CH-1:0]        err_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    if (CH < 2 || CH_W < $clog2(CH) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        VC_THRESH < 1 || VC_THRESH > DEPTH) begin : g_param_err
        $error("noc_link_mux: illegal parameters");
    end

    logic [DATA_W+1:0] mem [CH][DEPTH];
    logic [CW-1:0]     rd_ptr [CH];
    logic [CW-1:0]     wr_ptr [CH];
    logic [CW-1:0]     cnt [CH];
    logic [CH-1:0]     push, wr_en, pop, non_empty;
    logic [DATA_W+1:0] head;
    logic [CH_W-1:0]   rr_ptr, grant, sel, cand;
    logic              found, tail_pop;
    state_t            state, state_nx;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign in_ready[c]    = cnt[c] != CW'(DEPTH);
        assign in_vc_ready[c] = (CW'(DEPTH) - cnt[c]) >= CW'(VC_THRESH);
        assign non_empty[c]   = cnt[c] != '0;
        assign pop[c]         = out_valid & out_ready & (grant == CH_W'(c));
    end

    assign push = in_valid & in_ready;

`ifdef NOC_CONN_ERRCHK_EN
    logic [CH-1:0] in_pkt, legal, err_q;
    // A header is legal only outside a packet, any other flit only inside one.
    assign legal    = in_is_header ^ in_pkt;
    assign wr_en    = push & legal;
    assign err_flag = err_q;
    always_ff @(posedge noc_clk) begin
        if (rst) begin
            in_pkt <= '0;
            err_q  <= '0;
        end else begin
            in_pkt <= (in_pkt & ~wr_en) | (wr_en & ~in_is_tail);
            err_q  <= err_q | (push & ~legal);
        end
    end
`else
    assign wr_en    = push;
    assign err_flag = '0;
`endif

    always_ff @(posedge noc_clk) begin
        for (int c = 0; c < CH; c++)
            if (wr_en[c])
                mem[c][wr_ptr[c][AW-1:0]] <= {in_is_header[c], in_is_tail[c], in_flit[c*DATA_W +: DATA_W]};
    end

    always_ff @(posedge noc_clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                cnt[c]    <= '0;
            end else begin
                if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                cnt[c] <= cnt[c] + CW'(wr_en[c]) - CW'(pop[c]);
            end
        end
    end

    assign head          = mem[grant][rd_ptr[grant][AW-1:0]];
    assign out_valid     = (state == LOCKED) & non_empty[grant];
    assign out_flit      = head[DATA_W-1:0];
    assign out_is_header = head[DATA_W+1];
    assign out_is_tail   = head[DATA_W];
    assign out_ch        = grant;
    assign tail_pop      = out_valid & out_ready & out_is_tail;

    // Scan downward so the nearest non-empty channel above rr_ptr wins.
    always_comb begin
        sel   = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            cand = CH_W'((int'(rr_ptr) + i) % CH);
            if (non_empty[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        state_nx = (state == IDLE) ? (found ? LOCKED : IDLE) : (tail_pop ? IDLE : LOCKED);
    end

    always_ff @(posedge noc_clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) grant <= sel;
            if (state == LOCKED && tail_pop) rr_ptr <= (grant == CH_W'(CH - 1)) ? '0 : grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_link_mux.sv
// tb_noc_link_mux: directed stimulus with an expected-flit scoreboard checked by a separate output monitor.
module tb_noc_link_mux;
    localparam int CH = 4;
    localparam int DW = 64;

    logic          noc_clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] in_valid = '0, in_is_header = '0, in_is_tail = '0;
    logic [CH*DW-1:0] in_flit = '0;
    logic [CH-1:0] in_ready, in_vc_ready, err_flag;
    logic          out_valid, out_ready = 1'b0, out_is_header, out_is_tail;
    logic [DW-1:0] out_flit;
    logic [1:0]    out_ch;

    typedef struct {
        logic [1:0]    ch;
        logic          h;
        logic          t;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0, cyc = 0, tail_cyc = 0;
    bit   bub_chk = 0, have_tail = 0;

    noc_link_mux dut (
        .noc_clk(noc_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .in_is_header(in_is_header), .in_is_tail(in_is_tail),
        .in_vc_ready(in_vc_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_flit(out_flit), .out_is_header(out_is_header), .out_is_tail(out_is_tail),
        .out_ch(out_ch), .err_flag(err_flag)
    );

    always #5 noc_clk = ~noc_clk;
    always @(posedge noc_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic expect_flit(input int c, input logic h, input logic t, input logic [DW-1:0] d);
        exp_t e;
        e.ch = 2'(c); e.h = h; e.t = t; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int c, input logic h, input logic t, input logic [DW-1:0] d);
        in_valid[c] = 1'b1;
        in_is_header[c] = h;
        in_is_tail[c] = t;
        in_flit[c*DW +: DW] = d;
    endtask

    task automatic send(input int c, input logic h, input logic t, input logic [DW-1:0] d, input bit ex);
        drive(c, h, t, d);
        if (ex) expect_flit(c, h, t, d);
        tick();
        in_valid[c] = 1'b0;
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        in_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge noc_clk) begin
        exp_t e;
        if (!bub_chk) have_tail = 0;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got ch%0d flit %0h, expected no output", out_ch, out_flit);
            end else begin
                e = exp_q.pop_front();
                chk("out_ch", 64'(out_ch), 64'(e.ch));
                chk("out_flit", out_flit, e.d);
                chk("out_is_header", 64'(out_is_header), 64'(e.h));
                chk("out_is_tail", 64'(out_is_tail), 64'(e.t));
                if (bub_chk && out_is_header && have_tail) chk("bubble_gap", 64'(cyc - tail_cyc), 64'd2);
                if (out_is_tail) begin
                    have_tail = 1;
                    tail_cyc = cyc;
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] v;
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'hF);
        chk("rst_vc_ready", 64'(in_vc_ready), 64'hF);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_err_flag", 64'(err_flag), 64'd0);

        // single-flit packet on ch2: two-cycle latency from idle
        out_ready = 1'b1;
        send(2, 1'b1, 1'b1, 64'hA5, 1);
        chk("t1_valid_early", 64'(out_valid), 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'hF);
        chk("t1_vc_ready", 64'(in_vc_ready), 64'hF);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_ch", 64'(out_ch), 64'd2);
        chk("t1_flit", out_flit, 64'hA5);
        chk("t1_in_ready2", 64'(in_ready), 64'hF);
        tick();
        chk("t1_valid_after", 64'(out_valid), 64'd0);
        chk("t1_vc_ready2", 64'(in_vc_ready), 64'hF);

        // fill ch0 while the link is stalled
        out_ready = 1'b0;
        send(0, 1'b1, 1'b0, 64'h10, 1);
        chk("t2_rdy_1", 64'(in_ready[0]), 64'd1);
        chk("t2_vc_1", 64'(in_vc_ready[0]), 64'd1);
        send(0, 1'b0, 1'b0, 64'h20, 1);
        chk("t2_vc_2", 64'(in_vc_ready[0]), 64'd1);
        send(0, 1'b0, 1'b0, 64'h30, 1);
        chk("t2_rdy_3", 64'(in_ready[0]), 64'd1);
        chk("t2_vc_3", 64'(in_vc_ready[0]), 64'd0);
        send(0, 1'b0, 1'b1, 64'h40, 1);
        chk("t2_rdy_4", 64'(in_ready[0]), 64'd0);
        chk("t2_vc_4", 64'(in_vc_ready[0]), 64'd0);
        send(0, 1'b1, 1'b1, 64'h99, 0);
        chk("t2_rdy_5", 64'(in_ready[0]), 64'd0);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("t2_drained_rdy", 64'(in_ready), 64'hF);
        chk("t2_drained_vc", 64'(in_vc_ready), 64'hF);

        // simultaneous 3-flit packets on ch0, ch1, ch3
        do_reset();
        out_ready = 1'b1;
        bub_chk = 1;
        foreach (exp_q[i]) begin end
        for (int c = 0; c < CH; c++)
            if (c != 2)
                for (int k = 0; k < 3; k++) expect_flit(c, k == 0, k == 2, 64'(c * 16 + k));
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < CH; c++)
                if (c != 2) drive(c, k == 0, k == 2, 64'(c * 16 + k));
            tick();
            in_valid = '0;
        end
        repeat (14) tick();
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
        bub_chk = 0;

        // wormhole hold: ch1 stalls mid-packet while ch2 waits
        send(1, 1'b1, 1'b0, 64'h200, 1);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) send(2, k == 0, k == 2, 64'(64'h300 + k), 0);
        repeat (5) begin
            tick();
            chk("t4_hold_valid", 64'(out_valid), 64'd0);
            chk("t4_hold_ch", 64'(out_ch), 64'd1);
        end
        bub_chk = 1;
        send(1, 1'b0, 1'b0, 64'h201, 1);
        send(1, 1'b0, 1'b1, 64'h202, 1);
        for (int k = 0; k < 3; k++) expect_flit(2, k == 0, k == 2, 64'(64'h300 + k));
        repeat (8) tick();
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
        bub_chk = 0;

        // reset while ch0 is locked mid-packet with a buffered flit
        send(0, 1'b1, 1'b0, 64'h50, 1);
        repeat (2) tick();
        out_ready = 1'b0;
        send(0, 1'b0, 1'b0, 64'h51, 0);
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        chk("t5_rst_in_ready", 64'(in_ready), 64'hF);
        tick();
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'hF);
        chk("t5_vc_ready", 64'(in_vc_ready), 64'hF);
        chk("t5_out_ch", 64'(out_ch), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        send(3, 1'b1, 1'b1, 64'h77, 1);
        tick();
        chk("t5_new_valid", 64'(out_valid), 64'd1);
        chk("t5_new_ch", 64'(out_ch), 64'd3);
        tick();

        // body flit on an idle channel
        v = 64'h11;
        drive(1, 1'b0, 1'b0, v);
        chk("t6_ack", 64'(in_ready[1]), 64'd1);
`ifdef NOC_CONN_ERRCHK_EN
        tick();
        in_valid[1] = 1'b0;
        repeat (4) tick();
        chk("t6_err_flag", 64'(err_flag), 64'h2);
`else
        expect_flit(1, 1'b0, 1'b0, v);
        tick();
        in_valid[1] = 1'b0;
        repeat (4) tick();
        chk("t6_err_flag", 64'(err_flag), 64'h0);
`endif
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/noc_link_mux.md
# noc_link_mux

Parametrised N-channel NoC link connector: each input channel gets a flit FIFO with virtual-channel credit indication. A wormhole round-robin arbiter merges the channels onto one physical output link. A granted channel keeps the link until its tail flit leaves. Sits between router output ports (or network-interface injectors) and a shared inter-tile link.

## Interface
- CH, 4: number of input channels (≥2)
- CH_W, 2: channel-id width, ≥ clog2(CH)
- DATA_W, 64: flit payload width
- DEPTH, 4: per-channel FIFO depth, power of two, ≥2
- VC_THRESH, 2: minimum free slots for in_vc_ready, 1..DEPTH

Ports:
- noc_clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  CH  per-channel flit valid
- in_ready  out  CH  per-channel FIFO not full
- in_flit  in  CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_is_header  in  CH  flit is packet header
- in_is_tail  in  CH  flit is packet tail (header+tail = single-flit packet)
- in_vc_ready  out  CH  free slots ≥ VC_THRESH
- out_valid  out  1  output flit valid
- out_ready  in  1  downstream accepts
- out_flit  out  DATA_W  output flit
- out_is_header  out  1  header marker of out_flit
- out_is_tail  out  1  tail marker of out_flit
- out_ch  out  CH_W  source channel of out_flit
- err_flag  out  CH  sticky per-channel protocol error

## Operation
- Per channel: FIFO of {header, tail, flit}, with read pointer, write pointer and count registers of width clog2(DEPTH)+1.
- Push: in_valid & in_ready. Pop: out_valid & out_ready on the granted channel.
- in_ready = (count != DEPTH). There is no full-bypass: a full FIFO refuses a push even in a cycle where it pops.
- Push and pop on the same FIFO in the same cycle leave the count unchanged.
- in_vc_ready = (DEPTH - count) ≥ VC_THRESH, combinational from the count register.
- Arbiter FSM, two states:
  - IDLE: pick the first non-empty channel scanning upward from rr_ptr, wrapping from CH-1 to 0. Register grant and go LOCKED. If no channel is non-empty, stay IDLE.
  - LOCKED: out_valid = FIFO[grant] non-empty. out_flit, out_is_header, out_is_tail, out_ch are driven combinationally from the FIFO head; out_ch = grant.
  - On a pop whose flit has tail=1: go to IDLE and set rr_ptr = grant+1 mod CH.
- A locked channel that runs empty mid-packet holds the link: out_valid=0 and no other channel is granted.
- Out-of-range or zero-width conditions are not supported. Parameters are checked at elaboration only.

## Timing
- Reset values:
  - FIFOs empty, state IDLE, rr_ptr 0, grant 0, err_flag 0.
  - Resulting outputs: in_ready all 1, in_vc_ready all 1, out_valid 0, out_ch 0.
- Reset asserted mid-packet discards all buffered flits and any lock on the next edge. in_ready stays 1 throughout reset.
- Latency when the link is IDLE: flit pushed at edge t, arbitration at edge t+1, out_valid high in the cycle after t+1 (2 cycles).
- Latency when the link is LOCKED to the same channel with an empty FIFO: out_valid in the cycle after the push edge (1 cycle).
- One IDLE bubble cycle follows every tail pop, including single-flit packets.
- out_flit is stable while out_valid=1 and out_ready=0.

## Configuration
- Macro: NOC_CONN_ERRCHK_EN.
- Defined: each channel has an in_pkt bit on the input side, checked on every push:
  - Legal flits are written normally. A header sets in_pkt and a tail clears it.
  - A header while in_pkt=1 is dropped and sets err_flag[c].
  - A non-header while in_pkt=0 is dropped and sets err_flag[c].
  - A dropped flit is still acknowledged: ready stays high and the flit is consumed but not written.
  - err_flag clears only on rst.
- Not defined: every pushed flit is written unchecked and err_flag is tied to 0. The port remains present.

## Test plan
- Reset then single-flit packet (header=tail=1, flit 0xA5) on ch2:
  - out_valid rises 2 cycles after the push, with out_ch=2 and out_flit=0xA5.
  - in_ready=4'b1111 and in_vc_ready=4'b1111 throughout.
- Fill ch0 with 4 flits while out_ready=0:
  - in_ready[0] falls after the 4th push, in_vc_ready[0] falls after the 3rd.
  - A 5th flit presented while full is not accepted.
- 3-flit packets presented simultaneously on ch0, ch1 and ch3 with out_ready=1:
  - Output order is ch0 packet, ch1 packet, ch3 packet, with no interleaving.
  - One bubble cycle between packets.
- Wormhole hold: ch1 header sent, ch1 stalls, ch2 has a full packet:
  - out_valid stays 0 until ch1 resumes and its tail leaves.
  - ch2 is granted after the bubble.
- Reset asserted while ch0 is mid-packet and locked:
  - Next cycle out_valid=0, all counts 0, state IDLE.
  - A new packet on ch3 is granted normally.
- With NOC_CONN_ERRCHK_EN, body flit 0x11 on idle ch1:
  - The flit is accepted but never appears on out_flit, and err_flag=4'b0010.
  - Without the macro, 0x11 is output and err_flag stays 0.
